// File: rtl/fix_accumulator.sv
// ---------------------------------------------------------------------------
// fix_accumulator
//
// Streaming fixed-point accumulator that sits directly after the FixPU
// multiplier. It sums N_TERMS consecutive signed products into one output
// sample in the same signed Q(n_int).(n_mant) format as its input. The running
// sum is kept in a wider register with guard bits, so it cannot overflow while
// a frame is being built. Narrowing back to the word width happens only when
// the result is registered on the output.
//
// Build option:
//   FIX_ACC_SAT_EN  defined   : the output is clamped to
//                               [-2^n_tot, 2^n_tot-1], and ovf is a sticky flag
//                               that is set whenever a clamped value is
//                               registered.
//                   undefined : the output keeps the low W bits of the sum
//                               (two's-complement wrap), and ovf is tied to 0.
//
// Parameters:
//   n_int    integer bits of the in/out words, sign bit excluded
//   n_mant   fractional bits of the in/out words
//   N_TERMS  number of products summed into each output sample (>= 1)
//
// Ports:
//   clk        clock
//   rstn       synchronous reset, active low; overrides every other input
//   clr        synchronous frame abort; also clears ovf; drops that cycle's input
//   in_data    signed product from the FixPU, W = n_int+n_mant+1 bits
//   in_valid   in_data is valid
//   in_ready   in_data is accepted this cycle when in_valid is also high
//   out_data   signed accumulated sum, W bits
//   out_valid  out_data is valid
//   out_ready  the consumer takes out_data this cycle
//   ovf        sticky overflow flag
// ---------------------------------------------------------------------------
module fix_accumulator #(
  parameter int n_int   = 8,
  parameter int n_mant  = 23,
  parameter int N_TERMS = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic [n_int+n_mant:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [n_int+n_mant:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ovf
);

  localparam int n_tot = n_int + n_mant;
  localparam int W     = n_tot + 1;
  localparam int W_ACC = W + $clog2(N_TERMS);
  // The frame counter needs at least one bit, even when N_TERMS == 1.
  localparam int CW    = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);
  localparam bit            SINGLE   = (N_TERMS == 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]              r_state;
  logic signed [W_ACC-1:0] r_acc;
  logic [CW-1:0]           r_count;
  logic [W-1:0]            r_out_data;
  logic                    r_out_valid;

  logic                    w_accept;
  logic                    w_emit;
  logic                    w_last;
  logic                    w_load_out;
  logic signed [W_ACC-1:0] w_in_sext;
  logic signed [W_ACC-1:0] w_sum;
  logic [W-1:0]            w_reduced;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // While a result is held, a new term can enter only in the same cycle the
  // result leaves. That is why the output stays at one result and the input
  // keeps running at full rate with no bubble.
  assign in_ready  = (r_state == HOLD) ? out_ready : 1'b1;
  assign w_accept  = in_valid & in_ready;
  assign w_emit    = r_out_valid & out_ready;

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign w_in_sext = W_ACC'($signed(in_data));

  // A new frame starts from the incoming term alone. Inside a frame, the term
  // is added to the running sum.
  assign w_sum     = (r_state == ACCUM) ? (r_acc + w_in_sext) : w_in_sext;

  assign w_last    = (r_state == ACCUM) && (r_count == LAST_CNT);

  // out_data is loaded when a frame completes. That is the last term in ACCUM,
  // or any accepted term when every frame has only one term.
  always_comb begin
    // NOTE: assign a default before any branch so that no path leaves the
    // signal unassigned; an unassigned path would infer a latch.
    w_load_out = 1'b0;
    if (w_accept) begin
      case (r_state)
        IDLE:    w_load_out = SINGLE;
        ACCUM:   w_load_out = w_last;
        HOLD:    w_load_out = SINGLE;
        default: w_load_out = 1'b0;
      endcase
    end
  end

`ifdef FIX_ACC_SAT_EN
  // The value fits in W bits only when every bit from the W-1 sign position up
  // to the top guard bit is equal. Otherwise the value is clamped toward the
  // sign of the full sum.
  logic [W_ACC-W:0] w_hi;
  logic             w_clamped;
  logic             r_ovf;

  assign w_hi      = w_sum[W_ACC-1:W-1];
  assign w_clamped = (|w_hi) & ~(&w_hi);

  always_comb begin
    w_reduced = w_sum[W-1:0];
    if (w_clamped) begin
      w_reduced = w_sum[W_ACC-1] ? {1'b1, {n_tot{1'b0}}} : {1'b0, {n_tot{1'b1}}};
    end
  end

  // Sticky flag. It is set in the same cycle a clamped result is registered
  // and is cleared only by rstn or clr.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
    end else if (w_load_out && w_clamped) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  // Two's-complement wrap: the guard bits are dropped.
  logic w_unused_hi;

  assign w_reduced   = w_sum[W-1:0];
  assign w_unused_hi = ^w_sum[W_ACC-1:W-1];
  assign ovf         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM and state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // here samples the pre-edge values of the others.
    if (!rstn) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load_out) begin
        r_out_data <= w_reduced;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc <= w_in_sext;
            if (SINGLE) begin
              r_count     <= '0;
              r_out_valid <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_count <= CW'(1);
              r_state <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (w_accept) begin
            if (w_last) begin
              r_acc       <= '0;
              r_count     <= '0;
              r_out_valid <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_acc   <= w_sum;
              r_count <= r_count + CW'(1);
            end
          end
        end

        HOLD: begin
          // In HOLD an accepted term always comes with an emit, because
          // in_ready follows out_ready here.
          if (w_emit) begin
            if (w_accept) begin
              r_acc <= w_in_sext;
              if (SINGLE) begin
                // The term that just entered is already a full frame. The new
                // result replaces the old one with no gap on out_valid.
                r_count     <= '0;
                r_out_valid <= 1'b1;
                r_state     <= HOLD;
              end else begin
                r_count     <= CW'(1);
                r_out_valid <= 1'b0;
                r_state     <= ACCUM;
              end
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
        end

        default: begin
          r_state     <= IDLE;
          r_acc       <= '0;
          r_count     <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
